// File: rtl/rf_xfer_seq_pkg.sv
// rtl/rf_xfer_seq_pkg.sv - shared cpu register ids, status bit positions and byte width
package rf_xfer_seq_pkg;
    localparam int BYTE     = 8;
    localparam int REG_ID_W = 3;

    typedef logic [REG_ID_W-1:0] reg_id_t;

    localparam reg_id_t REG_A  = 3'd0;
    localparam reg_id_t REG_X  = 3'd1;
    localparam reg_id_t REG_Y  = 3'd2;
    localparam reg_id_t REG_SP = 3'd3;
    localparam reg_id_t REG_P  = 3'd4;

    localparam int STATUS_N = 7;
    localparam int STATUS_Z = 1;
endpackage

// File: rtl/rf_xfer_seq_nz_flag_update.sv
// rtl/rf_xfer_seq_nz_flag_update.sv - merges N/Z of a result byte into a status byte
module nz_flag_update
    import rf_xfer_seq_pkg::*;
#(
    parameter int N_BIT = STATUS_N,
    parameter int Z_BIT = STATUS_Z
) (
    input  logic [BYTE-1:0] status_i,
    input  logic [BYTE-1:0] data_i,
    output logic [BYTE-1:0] status_o
);
    always_comb begin
        status_o        = status_i;
        status_o[N_BIT] = data_i[BYTE-1];
        status_o[Z_BIT] = (data_i == '0);
    end
endmodule

// File: rtl/rf_xfer_seq.sv
// rtl/rf_xfer_seq.sv - register-to-register transfer sequencer for the single-port register file
// Optional immediate-load path: RF_XFER_IMM_EN
module rf_xfer_seq
    import rf_xfer_seq_pkg::*;
#(
    parameter int NUM_REGS = 5,
    parameter int N_BIT    = STATUS_N,
    parameter int Z_BIT    = STATUS_Z
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    input  reg_id_t         req_src_i,
    input  reg_id_t         req_dst_i,
    input  logic            req_flags_i,
`ifdef RF_XFER_IMM_EN
    input  logic            req_imm_i,
    input  logic [BYTE-1:0] req_imm_data_i,
`endif
    output logic            ready_o,
    output logic            done_o,
    output logic            err_o,
    output reg_id_t         reg_addr_o,
    output logic            reg_we_o,
    output logic [BYTE-1:0] reg_data_o,
    input  logic [BYTE-1:0] reg_read_data_i,
    output logic            status_reg_we_o,
    output logic [BYTE-1:0] status_reg_o,
    input  logic [BYTE-1:0] status_reg_i
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, ERR} state_t;

    state_t          r_state;
    state_t          w_next;
    reg_id_t         r_src;
    reg_id_t         r_dst;
    logic            r_flags;
    logic [BYTE-1:0] r_data;
    logic            w_accept;
    logic            w_src_bad;
    logic            w_dst_bad;
    logic            w_imm;
    logic [BYTE-1:0] w_status_new;

    assign w_accept  = req_valid_i && (r_state == IDLE);
    assign w_src_bad = int'(req_src_i) >= NUM_REGS;
    assign w_dst_bad = int'(req_dst_i) >= NUM_REGS;
`ifdef RF_XFER_IMM_EN
    assign w_imm = req_imm_i;
`else
    assign w_imm = 1'b0;
`endif

    nz_flag_update #(
        .N_BIT (N_BIT),
        .Z_BIT (Z_BIT)
    ) u_nz (
        .status_i (status_reg_i),
        .data_i   (r_data),
        .status_o (w_status_new)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_flags <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_src   <= req_src_i;
                r_dst   <= req_dst_i;
                r_flags <= req_flags_i;
`ifdef RF_XFER_IMM_EN
                if (req_imm_i)
                    r_data <= req_imm_data_i;
`endif
            end
            if (r_state == READ)
                r_data <= reg_read_data_i;
        end
    end

    // All outputs decode from state so a reset drops the write strobes without waiting for a clock.
    always_comb begin
        w_next          = r_state;
        ready_o         = 1'b0;
        done_o          = 1'b0;
        err_o           = 1'b0;
        reg_addr_o      = '0;
        reg_we_o        = 1'b0;
        reg_data_o      = '0;
        status_reg_we_o = 1'b0;
        status_reg_o    = '0;
        case (r_state)
            IDLE: begin
                ready_o = 1'b1;
                if (req_valid_i) begin
                    if (w_imm)
                        w_next = w_dst_bad ? ERR : WRITE;
                    else
                        w_next = (w_src_bad || w_dst_bad) ? ERR : READ;
                end
            end
            READ: begin
                reg_addr_o = r_src;
                w_next     = WRITE;
            end
            WRITE: begin
                reg_addr_o = r_dst;
                reg_we_o   = 1'b1;
                reg_data_o = r_data;
                done_o     = 1'b1;
                if (r_flags) begin
                    status_reg_we_o = 1'b1;
                    status_reg_o    = w_status_new;
                end
                w_next = IDLE;
            end
            ERR: begin
                done_o = 1'b1;
                err_o  = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rf_xfer_seq.sv
// tb/tb_rf_xfer_seq.sv - scoreboard bench for rf_xfer_seq with a register file model
module tb_rf_xfer_seq;
    import rf_xfer_seq_pkg::*;

    typedef struct {
        logic       err;
        logic [2:0] addr;
        logic       we;
        logic [7:0] data;
        logic       swe;
        logic [7:0] st;
        int         lat;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       req_valid_i = 1'b0;
    reg_id_t    req_src_i = '0;
    reg_id_t    req_dst_i = '0;
    logic       req_flags_i = 1'b0;
`ifdef RF_XFER_IMM_EN
    logic       req_imm_i = 1'b0;
    logic [7:0] req_imm_data_i = 8'h00;
`endif
    logic       ready_o, done_o, err_o, reg_we_o, status_reg_we_o;
    reg_id_t    reg_addr_o;
    logic [7:0] reg_data_o, reg_read_data_i, status_reg_o;

    logic [7:0] rf [8];
    logic [7:0] status;
    logic       pk_en = 1'b0;
    logic [2:0] pk_addr = '0;
    logic [7:0] pk_data = '0;
    logic       pk_status = 1'b0;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    exp_t expq[$];
    logic [2:0] rdq[$];

    always #5 clk_i = ~clk_i;

    rf_xfer_seq dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_src_i       (req_src_i),
        .req_dst_i       (req_dst_i),
        .req_flags_i     (req_flags_i),
`ifdef RF_XFER_IMM_EN
        .req_imm_i       (req_imm_i),
        .req_imm_data_i  (req_imm_data_i),
`endif
        .ready_o         (ready_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .reg_addr_o      (reg_addr_o),
        .reg_we_o        (reg_we_o),
        .reg_data_o      (reg_data_o),
        .reg_read_data_i (reg_read_data_i),
        .status_reg_we_o (status_reg_we_o),
        .status_reg_o    (status_reg_o),
        .status_reg_i    (status)
    );

    assign reg_read_data_i = rf[reg_addr_o];

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (pk_en) begin
            if (pk_status) status <= pk_data;
            else           rf[pk_addr] <= pk_data;
        end
        if (reg_we_o)        rf[reg_addr_o] <= reg_data_o;
        if (status_reg_we_o) status <= status_reg_o;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (done_o) begin
                if (expq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("done_err", err_o, e.err);
                    chk("done_addr", reg_addr_o, e.addr);
                    chk("done_we", reg_we_o, e.we);
                    chk("done_data", reg_data_o, e.data);
                    chk("done_status_we", status_reg_we_o, e.swe);
                    if (e.swe) chk("done_status", status_reg_o, e.st);
                    chk("done_latency", cyc - acc_cyc, e.lat);
                end
            end else if (!ready_o) begin
                if (rdq.size() == 0) begin
                    chk("unexpected_read", 1, 0);
                end else begin
                    chk("read_addr", reg_addr_o, rdq.pop_front());
                    chk("read_we", {reg_we_o, status_reg_we_o, reg_data_o}, 0);
                end
            end else begin
                chk("idle_outputs", {done_o, err_o, reg_we_o, status_reg_we_o,
                                     reg_addr_o, reg_data_o, status_reg_o}, 0);
            end
            if (req_valid_i && ready_o) acc_cyc = cyc;
        end
    end

    task automatic poke(input logic [2:0] a, input logic [7:0] d, input logic is_status);
        pk_en = 1'b1; pk_addr = a; pk_data = d; pk_status = is_status;
        @(posedge clk_i) #1;
        pk_en = 1'b0;
    endtask

    task automatic push(input logic err, input logic [2:0] a, input logic we, input logic [7:0] d,
                        input logic swe, input logic [7:0] st, input int lat);
        exp_t e;
        e.err = err; e.addr = a; e.we = we; e.data = d; e.swe = swe; e.st = st; e.lat = lat;
        expq.push_back(e);
    endtask

    // hold keeps req_valid_i high with different fields while busy; such requests must be ignored.
    task automatic xfer(input logic [2:0] s, input logic [2:0] d, input logic f,
                        input logic imm, input logic [7:0] imm_d, input logic hold);
        req_src_i = s; req_dst_i = d; req_flags_i = f; req_valid_i = 1'b1;
`ifdef RF_XFER_IMM_EN
        req_imm_i = imm; req_imm_data_i = imm_d;
`else
        if (imm || (imm_d != 8'h00)) chk("imm_unsupported", 1, 0);
`endif
        @(posedge clk_i) #1;
        req_src_i = 3'd3; req_dst_i = 3'd4; req_flags_i = 1'b1;
`ifdef RF_XFER_IMM_EN
        req_imm_i = 1'b0;
`endif
        if (hold) begin
            @(posedge clk_i) #1;
            @(posedge clk_i) #1;
        end
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (expq.size() != 0 || rdq.size() != 0); i++)
            @(posedge clk_i);
        #1;
        if (expq.size() != 0 || rdq.size() != 0) begin
            chk("drain_timeout", expq.size() + rdq.size(), 0);
            expq.delete();
            rdq.delete();
        end
        @(posedge clk_i) #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;
        status = 8'h00;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_ready", ready_o, 1);
        chk("reset_outputs", {done_o, err_o, reg_we_o, status_reg_we_o,
                              reg_addr_o, reg_data_o, status_reg_o}, 0);
        rst_i = 1'b0;
        @(posedge clk_i) #1;

        poke(3'd0, 8'h80, 1'b0);
        poke(3'd1, 8'h00, 1'b0);
        poke(3'd4, 8'h33, 1'b0);
        poke(3'd0, 8'h24, 1'b1);
        // TAX with flags
        rdq.push_back(3'd0);
        push(0, 3'd1, 1, 8'h80, 1, 8'hA4, 2);
        xfer(3'd0, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0);
        drain();
        chk("tax_x", rf[1], 8'h80);

        // TAY with flags, zero result
        poke(3'd0, 8'h00, 1'b0);
        poke(3'd0, 8'h80, 1'b1);
        rdq.push_back(3'd0);
        push(0, 3'd2, 1, 8'h00, 1, 8'h02, 2);
        xfer(3'd0, 3'd2, 1'b1, 1'b0, 8'h00, 1'b0);
        drain();

        // TXS without flags
        poke(3'd1, 8'h5A, 1'b0);
        rdq.push_back(3'd1);
        push(0, 3'd3, 1, 8'h5A, 0, 8'h00, 2);
        xfer(3'd1, 3'd3, 1'b0, 1'b0, 8'h00, 1'b0);
        drain();
        chk("txs_status_unchanged", status, 8'h02);

        // illegal dst then illegal src
        push(1, 3'd0, 0, 8'h00, 0, 8'h00, 1);
        xfer(3'd0, 3'd5, 1'b1, 1'b0, 8'h00, 1'b0);
        drain();
        push(1, 3'd0, 0, 8'h00, 0, 8'h00, 1);
        xfer(3'd7, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        drain();

        // src == dst with flags
        rdq.push_back(3'd1);
        push(0, 3'd1, 1, 8'h5A, 1, 8'h00, 2);
        xfer(3'd1, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0);
        drain();

        // TYA with a competing request held while busy
        poke(3'd2, 8'hC3, 1'b0);
        rdq.push_back(3'd2);
        push(0, 3'd0, 1, 8'hC3, 1, 8'h80, 2);
        xfer(3'd2, 3'd0, 1'b1, 1'b0, 8'h00, 1'b1);
        drain();

        // reset in the middle of a TAX write
        rdq.push_back(3'd0);
        req_src_i = 3'd0; req_dst_i = 3'd1; req_flags_i = 1'b1; req_valid_i = 1'b1;
        @(posedge clk_i) #1;
        req_valid_i = 1'b0;
        @(posedge clk_i) #1;
        chk("pre_reset_we", reg_we_o, 1);
        rst_i = 1'b1;
        #1;
        chk("reset_abort_we", {reg_we_o, status_reg_we_o}, 0);
        chk("reset_abort_done", done_o, 0);
        chk("reset_abort_ready", ready_o, 1);
        @(posedge clk_i) #1;
        rst_i = 1'b0;
        @(posedge clk_i) #1;
        chk("reset_abort_x", rf[1], 8'h5A);
        chk("reset_abort_status", status, 8'h80);
        chk("abort_rd_popped", rdq.size(), 0);

`ifdef RF_XFER_IMM_EN
        push(0, 3'd0, 1, 8'h00, 1, 8'h02, 1);
        xfer(3'd7, 3'd0, 1'b1, 1'b1, 8'h00, 1'b0);
        drain();
        chk("imm_a", rf[0], 8'h00);
        chk("imm_status", status, 8'h02);
`else
        chk("final_a", rf[0], 8'hC3);
        chk("final_status", status, 8'h80);
`endif
        chk("final_x", rf[1], 8'h5A);
        chk("final_y", rf[2], 8'hC3);
        chk("final_sp", rf[3], 8'h5A);
        chk("final_p_untouched", rf[4], 8'h33);
        chk("final_queues", expq.size() + rdq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
